// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: byte-wide external memory bus.
//   bus_addr  [31:0] byte address            (master -> slave)
//   bus_wdata [7:0]  byte write data         (master -> slave)
//   bus_re / bus_we  read / write strobes    (master -> slave), held until ack
//   bus_rdata [7:0]  byte read data          (slave -> master), valid with ack
//   bus_ack          byte transfer complete  (slave -> master)
interface mem_access_unit_if;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_re, bus_we,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_re, bus_we,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns a 32-bit word load/store from the CPU into four byte
// transfers on a byte-wide memory bus, little-endian (byte 0 at the lowest address).
//   CLK, RESET         clock, asynchronous active-high reset
//   MemRead, MemWrite  level requests from CONTROL (write wins when both are set)
//   ALUOut             byte address, must be word aligned
//   ReadData2          store data
//   ReadData3          load result, holds the last loaded word
//   Stall              holds PC/IR while an access is pending or in flight
//   MemDone            one-cycle pulse when an access retires
//   AlignErr           one-cycle pulse after a misaligned request is rejected
//   BusErr             one-cycle pulse when a byte transfer times out
//   bus                byte bus master (see mem_access_unit_if)
module mem_access_unit (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              ALUOut,
  input  logic [31:0]              ReadData2,
  output logic [31:0]              ReadData3,
  output logic                     Stall,
  output logic                     MemDone,
  output logic                     AlignErr,
  output logic                     BusErr,
  mem_access_unit_if.master        bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      r_state,     w_state_nxt;
  logic [31:2] r_addr,      w_addr_nxt;
  logic [31:0] r_data,      w_data_nxt;
  logic        r_we,        w_we_nxt;
  logic [1:0]  r_idx,       w_idx_nxt;
  logic [3:0]  r_tmo,       w_tmo_nxt;
  logic [31:0] r_rdata,     w_rdata_nxt;
  logic        r_align_err, w_align_err_nxt;
  logic        r_bus_err,   w_bus_err_nxt;

  logic w_req;
  logic w_misaligned;

  assign w_req        = MemRead | MemWrite;
  assign w_misaligned = (ALUOut[1:0] != 2'b00);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_idx       <= 2'd0;
      r_tmo       <= 4'd0;
      r_rdata     <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_we        <= w_we_nxt;
      r_idx       <= w_idx_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rdata     <= w_rdata_nxt;
      r_align_err <= w_align_err_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_we_nxt        = r_we;
    w_idx_nxt       = r_idx;
    w_tmo_nxt       = r_tmo;
    w_rdata_nxt     = r_rdata;
    w_align_err_nxt = 1'b0;
    w_bus_err_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_misaligned) begin
            w_align_err_nxt = 1'b1;
          end else begin
            w_addr_nxt  = ALUOut[31:2];
            w_data_nxt  = ReadData2;
            w_we_nxt    = MemWrite;  // write wins over a simultaneous read
            w_idx_nxt   = 2'd0;
            w_tmo_nxt   = 4'd0;
            w_state_nxt = StAccess;
          end
        end
      end
      StAccess: begin
        if (bus.bus_ack) begin
          if (!r_we) begin
            w_rdata_nxt[{r_idx, 3'b000} +: 8] = bus.bus_rdata;
          end
          w_idx_nxt = r_idx + 2'd1;
          w_tmo_nxt = 4'd0;
          if (r_idx == 2'd3) begin
            w_state_nxt = StDone;
          end
        end else if (r_tmo == 4'd14) begin
          // This no-ack cycle brings the count to 15: give up on the rest of the word.
          w_tmo_nxt     = 4'd15;
          w_bus_err_nxt = 1'b1;
          w_state_nxt   = StDone;
        end else begin
          w_tmo_nxt = r_tmo + 4'd1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.bus_addr  = 32'd0;
    bus.bus_wdata = 8'd0;
    bus.bus_re    = 1'b0;
    bus.bus_we    = 1'b0;
    if (r_state == StAccess) begin
      // Index is only two bits wide, so it can never carry into the word address.
      bus.bus_addr  = {r_addr, r_idx};
      bus.bus_wdata = r_data[{r_idx, 3'b000} +: 8];
      bus.bus_re    = !r_we;
      bus.bus_we    = r_we;
    end
  end

  // RESET gates the IDLE look-ahead stall so it drops immediately.
  assign Stall     = !RESET && ((r_state == StAccess) ||
                                ((r_state == StIdle) && w_req && !w_misaligned));
  assign MemDone   = (r_state == StDone);
  assign AlignErr  = r_align_err;
  assign BusErr    = r_bus_err;
  assign ReadData3 = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a byte memory
// responder with programmable ack delay and per-byte ack enable.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUOut;
  logic [31:0] ReadData2;
  logic [31:0] ReadData3;
  logic        Stall;
  logic        MemDone;
  logic        AlignErr;
  logic        BusErr;

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUOut    (ALUOut),
    .ReadData2 (ReadData2),
    .ReadData3 (ReadData3),
    .Stall     (Stall),
    .MemDone   (MemDone),
    .AlignErr  (AlignErr),
    .BusErr    (BusErr),
    .bus       (bus_if.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Responder controls, written only by the main initial block.
  logic [7:0] mem [256];
  logic [3:0] ack_en;
  int         ack_delay;
  logic       ack_force;

  // Responder logs, written only by the responder.
  int          n_re;
  int          n_we;
  int          n_acks;
  int          wait_cnt;
  logic [31:0] ack_addr  [64];
  logic [7:0]  ack_wdata [64];
  logic        ack_is_we [64];

  initial begin
    n_re = 0; n_we = 0; n_acks = 0; wait_cnt = 0;
  end

  always @(negedge CLK) begin
    if (bus_if.bus_re || bus_if.bus_we) begin
      if (bus_if.bus_re) n_re++;
      if (bus_if.bus_we) n_we++;
      if (ack_en[bus_if.bus_addr[1:0]] && (wait_cnt >= ack_delay)) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = mem[bus_if.bus_addr[7:0]];
        if (n_acks < 64) begin
          ack_addr[n_acks]  = bus_if.bus_addr;
          ack_wdata[n_acks] = bus_if.bus_wdata;
          ack_is_we[n_acks] = bus_if.bus_we;
        end
        n_acks++;
        wait_cnt = 0;
      end else begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'hFF;
        wait_cnt++;
      end
    end else begin
      bus_if.bus_ack   = ack_force;
      bus_if.bus_rdata = 8'hFF;
      wait_cnt = 0;
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Results of the last run_access.
  int   base_acks, base_re, base_we;
  int   stall_cnt, done_cyc, buserr_cyc;
  logic req_stall;

  // Present a request for one cycle, then count cycles until MemDone (bounded).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdat);
    @(negedge CLK);
    MemRead   = rd;
    MemWrite  = wr;
    ALUOut    = addr;
    ReadData2 = wdat;
    base_acks = n_acks;
    base_re   = n_re;
    base_we   = n_we;
    #1 req_stall = Stall;
    @(negedge CLK);
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    stall_cnt  = 0;
    done_cyc   = -1;
    buserr_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge CLK);
      if (Stall) stall_cnt++;
      if (BusErr) buserr_cyc = c;
      if (MemDone) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  logic [31:0] saved;

  initial begin
    n_vec = 0; n_err = 0;
    RESET = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUOut = '0; ReadData2 = '0;
    ack_en = 4'hF; ack_delay = 0; ack_force = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[8'h10] = 8'h0A; mem[8'h11] = 8'h0B; mem[8'h12] = 8'h0C; mem[8'h13] = 8'h0D;
    mem[8'h20] = 8'hE1; mem[8'h21] = 8'hE2; mem[8'h22] = 8'hE3; mem[8'h23] = 8'hE4;
    mem[8'h30] = 8'h5A; mem[8'h31] = 8'h6B; mem[8'h32] = 8'h7C; mem[8'h33] = 8'h8D;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst_rd3",     ReadData3,               32'h0);
    chk("rst_stall",   32'(Stall),              32'h0);
    chk("rst_done",    32'(MemDone),            32'h0);
    chk("rst_re_we",   32'({bus_if.bus_re, bus_if.bus_we}), 32'h0);
    chk("rst_addr",    bus_if.bus_addr,         32'h0);
    RESET = 1'b0;

    // Load at 0x10, ack always high.
    ack_delay = 0; ack_en = 4'hF;
    run_access(1'b1, 1'b0, 32'h10, 32'h0);
    chk("ld_req_stall", 32'(req_stall), 32'h1);
    chk("ld_stall_cnt", stall_cnt, 4);
    chk("ld_done_cyc",  done_cyc,  5);
    chk("ld_buserr",    buserr_cyc, 0);
    chk("ld_rd3",       ReadData3, 32'h0D0C0B0A);
    chk("ld_nacks",     n_acks - base_acks, 4);
    chk("ld_nwe",       n_we - base_we, 0);
    for (int k = 0; k < 4; k++) chk("ld_addr", ack_addr[base_acks + k], 32'h10 + k);

    // Store at 0x08, ack after two waits per byte.
    ack_delay = 2;
    run_access(1'b0, 1'b1, 32'h08, 32'h11223344);
    chk("st_stall_cnt", stall_cnt, 12);
    chk("st_done_cyc",  done_cyc,  13);
    chk("st_rd3",       ReadData3, 32'h0D0C0B0A);
    chk("st_nre",       n_re - base_re, 0);
    chk("st_nacks",     n_acks - base_acks, 4);
    chk("st_wd0", 32'(ack_wdata[base_acks + 0]), 32'h44);
    chk("st_wd1", 32'(ack_wdata[base_acks + 1]), 32'h33);
    chk("st_wd2", 32'(ack_wdata[base_acks + 2]), 32'h22);
    chk("st_wd3", 32'(ack_wdata[base_acks + 3]), 32'h11);
    for (int k = 0; k < 4; k++) chk("st_addr", ack_addr[base_acks + k], 32'h08 + k);

    // Misaligned load at 0x06.
    @(negedge CLK);
    MemRead = 1'b1; ALUOut = 32'h06; base_re = n_re;
    #1 chk("al_stall", 32'(Stall), 32'h0);
    @(negedge CLK);
    MemRead = 1'b0;
    chk("al_pulse", 32'(AlignErr), 32'h1);
    chk("al_no_re", 32'(bus_if.bus_re), 32'h0);
    @(negedge CLK);
    chk("al_pulse_end", 32'(AlignErr), 32'h0);
    chk("al_nre",       n_re - base_re, 0);
    chk("al_rd3",       ReadData3, 32'h0D0C0B0A);

    // Load at 0x20 with bytes 2-3 never acked: times out on byte 2.
    ack_delay = 0; ack_en = 4'b0011;
    run_access(1'b1, 1'b0, 32'h20, 32'h0);
    chk("to_done_cyc",  done_cyc,   18);
    chk("to_buserr",    buserr_cyc, 18);
    chk("to_stall_cnt", stall_cnt,  17);
    chk("to_nre",       n_re - base_re, 17);
    chk("to_rd3",       ReadData3, 32'h0D0CE2E1);
    @(negedge CLK);
    chk("to_buserr_end", 32'({BusErr, MemDone}), 32'h0);

    // Read and write together at 0x04: only the write happens.
    ack_delay = 1; ack_en = 4'hF;
    run_access(1'b1, 1'b1, 32'h04, 32'hA1B2C3D4);
    chk("rw_done_cyc",  done_cyc, 9);
    chk("rw_stall_cnt", stall_cnt, 8);
    chk("rw_nre",       n_re - base_re, 0);
    chk("rw_nwe",       n_we - base_we, 8);
    chk("rw_nacks",     n_acks - base_acks, 4);
    chk("rw_wd0", 32'(ack_wdata[base_acks + 0]), 32'hD4);
    chk("rw_wd3", 32'(ack_wdata[base_acks + 3]), 32'hA1);
    chk("rw_addr3", ack_addr[base_acks + 3], 32'h07);
    chk("rw_rd3",   ReadData3, 32'h0D0CE2E1);

    // Stray ack while idle is ignored.
    saved = ReadData3;
    @(negedge CLK);
    ack_force = 1'b1;
    repeat (3) @(negedge CLK);
    ack_force = 1'b0;
    chk("ia_rd3",  ReadData3, saved);
    chk("ia_done", 32'({MemDone, Stall}), 32'h0);

    // Reset in the middle of a load at 0x30, on byte 2.
    ack_delay = 0;
    @(negedge CLK);
    MemRead = 1'b1; ALUOut = 32'h30;
    @(negedge CLK);
    MemRead = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rs_byte2_addr", bus_if.bus_addr, 32'h32);
    chk("rs_byte2_re",   32'(bus_if.bus_re), 32'h1);
    #2 RESET = 1'b1;
    #1;
    chk("rs_re_drop", 32'(bus_if.bus_re), 32'h0);
    chk("rs_rd3",     ReadData3, 32'h0);
    chk("rs_addr",    bus_if.bus_addr, 32'h0);
    chk("rs_stall",   32'(Stall), 32'h0);
    repeat (2) begin
      @(negedge CLK);
      chk("rs_no_done", 32'({MemDone, BusErr}), 32'h0);
    end
    RESET = 1'b0;

    // Load after reset completes normally.
    run_access(1'b1, 1'b0, 32'h30, 32'h0);
    chk("pr_done_cyc", done_cyc, 5);
    chk("pr_rd3",      ReadData3, 32'h8D7C6B5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock domain; reset SHALL be asynchronous and active-high.
REQ-002 CLK  in  1  system clock; all state updates on posedge.
REQ-003 RESET  in  1  asynchronous active-high reset.
REQ-004 MemRead  in  1  load request from CONTROL, level.
REQ-005 MemWrite  in  1  store request from CONTROL, level.
REQ-006 ALUOut  in  32  byte address from the ALU.
REQ-007 ReadData2  in  32  store data from the register file.
REQ-008 ReadData3  out  32  load result to the write-back mux, little-endian.
REQ-009 Stall  out  1  holds the PC and instruction register while an access is in flight.
REQ-010 MemDone  out  1  one-cycle pulse when an access retires.
REQ-011 AlignErr  out  1  one-cycle pulse when a request has ALUOut[1:0] != 0.
REQ-012 BusErr  out  1  one-cycle pulse when a byte access times out.
REQ-013 bus_addr  out  32  byte address to external byte-wide memory.
REQ-014 bus_wdata  out  8  byte write data.
REQ-015 bus_re / bus_we  out  1 each  byte read / write strobes, held until ack.
REQ-016 bus_rdata  in  8  byte read data, valid with bus_ack.
REQ-017 bus_ack  in  1  byte transfer complete.

Function
REQ-018 States SHALL be IDLE, ACCESS and DONE.
REQ-019 IDLE: with MemWrite=1, the block SHALL sample the request at posedge; MemWrite SHALL take priority when both MemRead and MemWrite are 1, and the read is discarded.
REQ-020 IDLE: with MemRead=1 and MemWrite=0, the block SHALL sample a load request at posedge.
REQ-021 Misaligned request in IDLE: the block SHALL pulse AlignErr for 1 cycle, issue no bus activity, stay in IDLE and leave ReadData3 unchanged.
REQ-022 Aligned request in IDLE: the block SHALL latch ALUOut, ReadData2 and the direction, clear the byte index to 0, clear the timeout counter and go to ACCESS.
REQ-023 Stall SHALL be 1 combinationally in IDLE when an aligned request is present, and 1 throughout ACCESS; it SHALL be 0 otherwise.
REQ-024 In ACCESS the outputs SHALL be: bus_addr = {latched_addr[31:2], idx[1:0]}, bus_wdata = latched_data[8*idx+7:8*idx], and exactly one of bus_re/bus_we = 1.
REQ-025 bus_ack=1 at posedge in ACCESS, load: the block SHALL write bus_rdata into ReadData3[8*idx+7:8*idx], increment idx and clear the timeout counter.
REQ-026 bus_ack=1 at posedge in ACCESS, store: the block SHALL increment idx and clear the timeout counter.
REQ-027 An ack on idx=3 SHALL move the block to DONE.
REQ-028 Timeout: a 4-bit counter SHALL increment on each ACCESS cycle without ack; at count 15 without ack the block SHALL pulse BusErr, abandon the remaining bytes and go to DONE. Bytes already loaded into ReadData3 SHALL be kept.
REQ-029 DONE: the block SHALL assert MemDone=1 and Stall=0 for exactly 1 cycle, ignore requests, then return to IDLE.
REQ-030 A request still present on return to IDLE SHALL start a new access.
REQ-031 Latency: with bus_ack tied high, ACCESS SHALL last 4 cycles and MemDone SHALL assert in the 5th cycle after the request edge.
REQ-032 A store SHALL never modify ReadData3.
REQ-033 ReadData3 SHALL hold the last loaded value indefinitely.
REQ-034 bus_ack in IDLE or DONE SHALL be ignored.
REQ-035 The byte index SHALL never carry into bus_addr[31:2].

Reset
REQ-036 RESET=1 SHALL immediately force: state=IDLE, idx=0, counter=0, ReadData3=0, Stall=0, MemDone=0, AlignErr=0, BusErr=0, bus_re=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-037 RESET during ACCESS SHALL abort the access; partially loaded bytes SHALL be discarded (ReadData3=0), and no MemDone or BusErr SHALL be issued.
REQ-038 After RESET deasserts, the first posedge SHALL evaluate requests as IDLE.

Verification
REQ-039 Load, ALUOut=0x10, ack always high, memory bytes 0x10..0x13 = 0A,0B,0C,0D -> ReadData3=0x0D0C0B0A, Stall high 4 cycles, MemDone in cycle 5, bus_addr sequence 0x10,0x11,0x12,0x13.
REQ-040 Store, ALUOut=0x08, ReadData2=0x11223344, ack delayed 2 cycles per byte -> bus_wdata 44,33,22,11 on addresses 0x08..0x0B, Stall high 12 cycles, ReadData3 unchanged.
REQ-041 Load with ALUOut=0x06 -> AlignErr pulse 1 cycle, no bus_re, Stall=0, state stays IDLE.
REQ-042 Load at 0x20, ack given for bytes 0-1 only -> after 15 no-ack cycles on byte 2, BusErr and MemDone pulse; ReadData3[15:0] updated and [31:16] unchanged.
REQ-043 MemRead=MemWrite=1 at 0x04 -> only bus_we strobes observed, 4 bytes written.
REQ-044 RESET asserted at byte 2 of a load -> bus_re drops without waiting for a clock, ReadData3=0, no MemDone; next load after reset completes normally.
